stream_downsizer: RTL and testbench
===================================

Name: stream_downsizer

Overview:
- Width-converting stage directly downstream of stream_fifo.
- Each wide FIFO output word is serialised into RATIO narrow beats on a valid/ready stream.
- Optional packet framing: s_last_i marks a packet's final word, s_cnt_i gives its valid lane count, and m_last_o marks the final narrow beat.
- Zero-bubble: a new word is accepted in the same cycle the last beat of the current word is consumed.

Parameters:
- IN_W, 32: input word width; must be an integer multiple of OUT_W.
- OUT_W, 8: output beat width.
- MSB_FIRST, 0: 0 sends lane 0 (bits OUT_W-1:0) first; 1 sends the top lane first.
- Derived localparam RATIO = IN_W/OUT_W (must be ≥2), CNT_W = $clog2(RATIO+1).
- An illegal IN_W/OUT_W combination is an elaboration-time error.

Ports:
- clk, input, 1: sole clock, rising edge.
- rst, input, 1: synchronous, active-high reset.
- s_valid_i, input, 1: input word valid (from FIFO r_valid_o).
- s_ready_o, output, 1: input word accepted when s_valid_i && s_ready_o.
- s_data_i, input, IN_W: input word.
- s_last_i, input, 1: word is the last of its packet.
- s_cnt_i, input, CNT_W: valid lanes in a last word, 1..RATIO.
- m_valid_o, output, 1: output beat valid.
- m_ready_i, input, 1: sink ready.
- m_data_o, output, OUT_W: output beat.
- m_last_o, output, 1: final beat of the packet.

Behaviour:
- State:
  - buf_q (IN_W): captured word.
  - idx_q (CNT_W): current lane, 0..RATIO-1.
  - cnt_q (CNT_W): lanes to emit.
  - last_q: captured s_last_i.
  - full_q: buffer holds a word.
- Reset (rst=1 at clk edge):
  - full_q=0, idx_q=0, cnt_q=RATIO, last_q=0, buf_q=0.
  - Outputs: m_valid_o=0, m_last_o=0, m_data_o=0, s_ready_o=1.
  - Any partially sent word is discarded; no beat is emitted after reset.
- Derived signals:
  - fin = full_q && (idx_q == cnt_q-1).
  - s_ready_o = !full_q || (fin && m_ready_i). Combinational path from m_ready_i is intentional.
  - m_valid_o = full_q.
  - m_last_o = fin && last_q.
  - m_data_o = lane idx_q of buf_q, or lane RATIO-1-idx_q when MSB_FIRST=1.
- Capture (s_valid_i && s_ready_o):
  - buf_q <= s_data_i, last_q <= s_last_i, idx_q <= 0, full_q <= 1.
  - cnt_q <= RATIO when s_last_i=0, regardless of s_cnt_i.
  - When s_last_i=1: cnt_q <= s_cnt_i, except 0 or >RATIO, which clamp to RATIO.
- Beat consumption (m_valid_o && m_ready_i):
  - If !fin: idx_q <= idx_q+1.
  - If fin and no simultaneous capture: full_q <= 0, idx_q <= 0.
  - If fin with simultaneous capture: the capture rule wins and the first beat of the new word is valid the next cycle.
- Latency and throughput:
  - Word accepted at edge N → first beat valid after edge N.
  - With m_ready_i held high, one beat per cycle and no idle cycle between words.
  - A full packed word takes exactly RATIO beats.
- Stability: while m_valid_o=1 and m_ready_i=0, m_data_o, m_last_o and all state hold.
- Input side: s_data_i, s_last_i and s_cnt_i are sampled only on an accepted handshake; no X-propagation from them otherwise.
- Short word: a last word with cnt<RATIO emits only cnt beats; unused lanes are never presented.
- No combinational path from s_valid_i to m_valid_o.

Decomposition:
- Package stream_pkg:
  - Lane-count function clog2-based CNT_W helper.
  - Parameter-check macro/function.
  - Shared valid/ready interface typedef for reuse across 06_handshake blocks.
- No sub-module: lane select is a single indexed part-select, and the control logic is one small register set. Everything stays in stream_downsizer.

Test Plan:
- Reset then idle:
  - rst=1 for 2 cycles, then 0, s_valid_i=0 → m_valid_o=0, s_ready_o=1, m_last_o=0, m_data_o=0.
- Back-to-back full words, m_ready_i=1, MSB_FIRST=0:
  - Words 0x44332211 then 0x88776655 (last=1, cnt=4) → beats 11,22,33,44,55,66,77,88 on 8 consecutive cycles.
  - m_last_o only on 88.
  - s_ready_o high on the cycles of beats 44 and 88.
- Short last word:
  - 0xDDCCBBAA, last=1, cnt=2 → beats AA, BB; m_last_o on BB; next word accepted in the BB cycle.
  - Repeat with cnt=0 → 4 beats.
- Backpressure:
  - m_ready_i toggles 1,0,0,1,… during word 0x04030201 → each beat held stable across stall cycles.
  - Order 01,02,03,04; s_ready_o=0 until the cycle beat 04 is taken.
- MSB_FIRST=1 build:
  - 0x44332211 → beats 44,33,22,11.
- Mid-word reset:
  - After beat 22 of 0x44332211, assert rst for one cycle → m_valid_o=0 next cycle; beats 33/44 never appear.
  - Next word 0x0000AA55 → first beat 55.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared helpers for the valid/ready streaming blocks.
package stream_pkg;

    // Width of a counter that must hold 0..ratio inclusive.
    function automatic int cnt_w(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    // Legal width pair: in_w is a whole multiple of out_w, at least two lanes.
    function automatic bit ratio_ok(input int in_w, input int out_w);
        return (out_w > 0) && (in_w % out_w == 0) && (in_w / out_w >= 2);
    endfunction

    // Handshake pair shared by the stream blocks.
    typedef struct packed {
        logic valid;
        logic ready;
    } hs_t;

endpackage

// File: rtl/stream_downsizer.sv
// Serialises each wide input word into RATIO narrow beats, with optional
// packet framing (last flag plus valid lane count on the final word).
module stream_downsizer
    import stream_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int OUT_W     = 8,
    parameter int MSB_FIRST = 0,
    localparam int RATIO    = IN_W / OUT_W,
    localparam int CNT_W    = cnt_w(IN_W / OUT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [IN_W-1:0]  s_data_i,
    input  logic             s_last_i,
    input  logic [CNT_W-1:0] s_cnt_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [OUT_W-1:0] m_data_o,
    output logic             m_last_o
);

    generate
        if (!ratio_ok(IN_W, OUT_W)) begin : g_bad_ratio
            $error("stream_downsizer: IN_W must be a multiple of OUT_W with at least two lanes");
        end
    endgenerate

    localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    logic [IN_W-1:0]  buf_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic             last_q;
    logic             full_q;

    logic             fin;
    logic             s_fire;
    logic             m_fire;
    logic [CNT_W-1:0] lane;
    logic [CNT_W-1:0] cnt_in;

    // Final beat of the held word; frees the buffer for a same-cycle refill.
    assign fin       = full_q && (idx_q == cnt_q - ONE_C);
    assign s_ready_o = !full_q || (fin && m_ready_i);
    assign m_valid_o = full_q;
    assign m_last_o  = fin && last_q;
    assign s_fire    = s_valid_i && s_ready_o;
    assign m_fire    = full_q && m_ready_i;

    // Lane order is a build-time choice; only the index mapping changes.
    assign lane     = (MSB_FIRST != 0) ? (RATIO_C - ONE_C - idx_q) : idx_q;
    assign m_data_o = buf_q[int'(lane)*OUT_W +: OUT_W];

    // Non-last words always carry all lanes; out-of-range counts mean "full".
    assign cnt_in = (!s_last_i || s_cnt_i == '0 || s_cnt_i > RATIO_C) ? RATIO_C : s_cnt_i;

    // Capture takes priority over draining, so a refill on the final beat
    // starts the new word at lane 0 with no idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= RATIO_C;
            last_q <= 1'b0;
            full_q <= 1'b0;
        end else if (s_fire) begin
            buf_q  <= s_data_i;
            idx_q  <= '0;
            cnt_q  <= cnt_in;
            last_q <= s_last_i;
            full_q <= 1'b1;
        end else if (m_fire) begin
            if (fin) begin
                full_q <= 1'b0;
                idx_q  <= '0;
            end else begin
                idx_q  <= idx_q + ONE_C;
            end
        end
    end

endmodule

// File: tb/tb_stream_downsizer.sv
// Randomised plus directed bench: an LSB-first and an MSB-first instance see
// the same stimulus and are compared against a queue-of-beats model.
module tb_stream_downsizer;

    localparam int R = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic [2:0]  s_cnt = '0;
    logic        m_ready = 1'b0;

    logic        a_s_ready, a_m_valid, a_m_last;
    logic [7:0]  a_m_data;
    logic        b_s_ready, b_m_valid, b_m_last;
    logic [7:0]  b_m_data;

    int n_chk = 0;
    int n_err = 0;

    beat_t qa[$];
    beat_t qb[$];
    bit    armed = 0;
    bit    fresh = 0;
    bit    last_acc = 0;

    always #5 clk = ~clk;

    stream_downsizer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(0)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid_i(s_valid), .s_ready_o(a_s_ready), .s_data_i(s_data),
        .s_last_i(s_last), .s_cnt_i(s_cnt),
        .m_valid_o(a_m_valid), .m_ready_i(m_ready), .m_data_o(a_m_data),
        .m_last_o(a_m_last)
    );

    stream_downsizer #(.IN_W(32), .OUT_W(8), .MSB_FIRST(1)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid_i(s_valid), .s_ready_o(b_s_ready), .s_data_i(s_data),
        .s_last_i(s_last), .s_cnt_i(s_cnt),
        .m_valid_o(b_m_valid), .m_ready_i(m_ready), .m_data_o(b_m_data),
        .m_last_o(b_m_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an accepted word becomes a list of beats in emission order.
    task automatic model_push(input logic [31:0] d, input logic l, input logic [2:0] c);
        int n;
        n = (l && c >= 3'd1 && c <= 3'(R)) ? int'(c) : R;
        for (int i = 0; i < n; i++) begin
            qa.push_back('{d: d[i*8 +: 8],       l: l && (i == n-1)});
            qb.push_back('{d: d[(R-1-i)*8 +: 8], l: l && (i == n-1)});
        end
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cycle(input logic r, input logic sv, input logic [31:0] d,
                         input logic l, input logic [2:0] c, input logic mr);
        bit exp_rdy, pop, acc;
        @(negedge clk);
        rst = r; s_valid = sv; s_data = d; s_last = l; s_cnt = c; m_ready = mr;
        #1;
        exp_rdy = (qa.size() == 0) || (qa.size() == 1 && mr);
        if (armed) begin
            chk("a_m_valid", a_m_valid, qa.size() != 0);
            chk("b_m_valid", b_m_valid, qb.size() != 0);
            chk("a_s_ready", a_s_ready, exp_rdy);
            chk("b_s_ready", b_s_ready, exp_rdy);
            if (qa.size() != 0) begin
                chk("a_m_data", a_m_data, qa[0].d);
                chk("a_m_last", a_m_last, qa[0].l);
                chk("b_m_data", b_m_data, qb[0].d);
                chk("b_m_last", b_m_last, qb[0].l);
            end else begin
                chk("a_m_last_idle", a_m_last, 0);
                chk("b_m_last_idle", b_m_last, 0);
            end
            if (fresh) begin
                chk("a_m_data_rst", a_m_data, 0);
                chk("b_m_data_rst", b_m_data, 0);
            end
        end
        pop = (qa.size() != 0) && mr;
        acc = sv && exp_rdy && !r;
        @(posedge clk);
        if (r) begin
            qa.delete();
            qb.delete();
            fresh = 1;
            armed = 1;
            last_acc = 0;
        end else begin
            if (pop) begin
                void'(qa.pop_front());
                void'(qb.pop_front());
            end
            if (acc) begin
                model_push(d, l, c);
                fresh = 0;
            end
            last_acc = acc;
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic l, input logic [2:0] c, input logic mr);
        bit done;
        done = 0;
        for (int k = 0; k < 50 && !done; k++) begin
            cycle(0, 1, d, l, c, mr);
            done = last_acc;
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    // mode 0: sink always ready; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic drain(input int mode);
        for (int k = 0; k < 60 && qa.size() != 0; k++)
            cycle(0, 0, 32'h0, 0, 3'd0, (mode == 0) || (k % 3 == 0));
        if (qa.size() != 0) chk("drain_timeout", qa.size(), 0);
    endtask

    initial begin
        // Reset then idle
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 1);

        // Back-to-back full words, zero bubble between them
        push_word(32'h44332211, 0, 3'd0, 1);
        push_word(32'h88776655, 1, 3'd4, 1);
        drain(0);
        cycle(0, 0, 0, 0, 0, 1);

        // Short last word, then count 0 clamps to a full word
        push_word(32'hDDCCBBAA, 1, 3'd2, 1);
        push_word(32'hDDCCBBAA, 1, 3'd0, 1);
        push_word(32'h12345678, 1, 3'd7, 1);
        drain(0);

        // Backpressure with a stalling sink
        push_word(32'h04030201, 1, 3'd4, 1);
        drain(1);
        cycle(0, 0, 0, 0, 0, 0);

        // Mid-word reset discards the remaining beats
        push_word(32'h44332211, 0, 3'd0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 1);
        push_word(32'h0000AA55, 1, 3'd2, 1);
        drain(0);

        // Random traffic, including out-of-range counts and random stalls
        for (int k = 0; k < 600; k++)
            cycle(0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0));
        drain(0);
        cycle(0, 0, 0, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
